// File: rtl/edge_detect_pkg.sv
// rtl/edge_detect_pkg.sv - shared types, constants and helpers for the multi-channel edge detector
//
// Purpose : edge_mode_t encoding, mode width, default filter length,
//           debounce counter width helper and the edge qualification rule.
// Ports   : none (package).

package edge_detect_pkg;

  typedef enum logic [1:0] {
    OFF  = 2'b00,
    RISE = 2'b01,
    FALL = 2'b10,
    BOTH = 2'b11
  } edge_mode_t;

  localparam int MODE_W         = 2;
  localparam int DEF_FILTER_LEN = 3;

  // Debounce counter must hold values 0..FILTER_LEN-1; the +1 keeps
  // FILTER_LEN=1 at a legal 1-bit width.
  function automatic int dbc_width(input int filter_len);
    return $clog2(filter_len + 1);
  endfunction

  // True when an accepted level change to new_level is reportable in mode m.
  function automatic logic qualify(input edge_mode_t m, input logic new_level);
    if (new_level) begin
      return (m == RISE) || (m == BOTH);
    end
    return (m == FALL) || (m == BOTH);
  endfunction

endpackage

// File: rtl/multi_edge_detect_if.sv
// rtl/multi_edge_detect_if.sv - signal bundle between pad-side driver and the edge detector
//
// Purpose : groups the per-channel line/mode/clear inputs and the level/edge/flag
//           (and optional count) outputs of multi_edge_detect.
// Signals : line_i [NCH]      raw asynchronous lines
//           mode_i [2*NCH]    per-channel edge_mode_t
//           clr_i  [NCH]      sticky flag / counter clear
//           level_o [NCH]     filtered level
//           edge_o  [NCH]     one-cycle qualified edge pulse
//           any_edge_o        OR of edge_o
//           flag_o  [NCH]     sticky edge flag
//           cnt_o [CNT_W*NCH] saturating edge counts (EDGE_DETECT_CNT_EN only)
// Modports: master drives the inputs (pad side / bench), slave is the detector.

interface multi_edge_detect_if #(
  parameter int NCH   = 4,
  parameter int CNT_W = 8
);

  logic [NCH-1:0]   line_i;
  logic [2*NCH-1:0] mode_i;
  logic [NCH-1:0]   clr_i;
  logic [NCH-1:0]   level_o;
  logic [NCH-1:0]   edge_o;
  logic             any_edge_o;
  logic [NCH-1:0]   flag_o;
`ifdef EDGE_DETECT_CNT_EN
  logic [CNT_W*NCH-1:0] cnt_o;
`endif

  modport master (
    output line_i, mode_i, clr_i,
    input  level_o, edge_o, any_edge_o, flag_o
`ifdef EDGE_DETECT_CNT_EN
    , input cnt_o
`endif
  );

  modport slave (
    input  line_i, mode_i, clr_i,
    output level_o, edge_o, any_edge_o, flag_o
`ifdef EDGE_DETECT_CNT_EN
    , output cnt_o
`endif
  );

endinterface

// File: rtl/edge_chan.sv
// rtl/edge_chan.sv - one edge detector channel: sync, debounce, qualify, sticky flag, optional count
//
// Purpose : synchronises one raw line, accepts a level change only after
//           FILTER_LEN consecutive differing samples, and reports the change
//           as a one-cycle pulse when the channel mode asks for that polarity.
// Ports   : clk, rst        clock, synchronous active-high reset
//           line            raw asynchronous line
//           mode            edge_mode_t, sampled only on an accepted change
//           clr             sticky flag (and counter) clear; a same-cycle edge wins
//           level           filtered level
//           edge_pulse      registered qualified edge
//           edge_nxt        value edge_pulse takes at the next clk edge
//           flag            sticky edge flag
//           cnt             saturating edge count (EDGE_DETECT_CNT_EN only)
// Config  : EDGE_DETECT_CNT_EN adds the CNT_W parameter, the counter and cnt.

module edge_chan
  import edge_detect_pkg::*;
#(
  parameter int   SYNC_STAGES = 2,
  parameter int   FILTER_LEN  = DEF_FILTER_LEN,
  parameter logic IDLE_BIT    = 1'b1
`ifdef EDGE_DETECT_CNT_EN
  , parameter int CNT_W       = 8
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       line,
  input  edge_mode_t mode,
  input  logic       clr,
  output logic       level,
  output logic       edge_pulse,
  output logic       edge_nxt,
  output logic       flag
`ifdef EDGE_DETECT_CNT_EN
  , output logic [CNT_W-1:0] cnt
`endif
);

  localparam int DBW = dbc_width(FILTER_LEN);
  localparam logic [DBW-1:0] DBC_LAST = DBW'(FILTER_LEN - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [DBW-1:0]         dbc_q;
  logic                   level_q;
  logic                   edge_q;
  logic                   flag_q;

  logic s;
  logic differ;
  logic update;

  assign s      = sync_q[SYNC_STAGES-1];
  assign differ = (s != level_q);
  // The FILTER_LEN-th consecutive differing sample commits the new level.
  assign update = differ && (dbc_q == DBC_LAST);

  always_comb begin
    edge_nxt = 1'b0;
    if (update) begin
      edge_nxt = qualify(mode, s);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= {SYNC_STAGES{IDLE_BIT}};
      dbc_q   <= '0;
      level_q <= IDLE_BIT;
      edge_q  <= 1'b0;
      flag_q  <= 1'b0;
    end else begin
      sync_q[0] <= line;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end

      // Any sample agreeing with the current level restarts the debounce.
      if (!differ) begin
        dbc_q <= '0;
      end else if (update) begin
        dbc_q   <= '0;
        level_q <= s;
      end else begin
        dbc_q <= dbc_q + 1'b1;
      end

      edge_q <= edge_nxt;
      // Set has priority over a simultaneous clear.
      flag_q <= edge_nxt | (flag_q & ~clr);
    end
  end

`ifdef EDGE_DETECT_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      // Clear with a coincident edge leaves that edge counted.
      cnt_q <= edge_nxt ? CNT_W'(1) : '0;
    end else if (edge_nxt && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cnt = cnt_q;
`endif

  assign level      = level_q;
  assign edge_pulse = edge_q;
  assign flag       = flag_q;

endmodule

// File: rtl/multi_edge_detect.sv
// rtl/multi_edge_detect.sv - parametrised multi-channel synchronising, debouncing edge detector
//
// Purpose : NCH independent edge_chan instances between pad-level lines and the
//           decode/timer FSMs, plus a registered OR of all channel pulses.
// Ports   : clk   system clock
//           rst   synchronous active-high reset
//           bus   multi_edge_detect_if.slave (line_i, mode_i, clr_i in;
//                 level_o, edge_o, any_edge_o, flag_o, cnt_o out)
// Config  : EDGE_DETECT_CNT_EN enables per-channel saturating edge counters
//           and drives bus.cnt_o; without it there is no counter logic.

module multi_edge_detect
  import edge_detect_pkg::*;
#(
  parameter int             NCH         = 4,
  parameter int             SYNC_STAGES = 2,
  parameter int             FILTER_LEN  = DEF_FILTER_LEN,
  parameter logic [NCH-1:0] IDLE_VAL    = '1,
  parameter int             CNT_W       = 8
) (
  input logic                clk,
  input logic                rst,
  multi_edge_detect_if.slave bus
);

  if (NCH < 1 || SYNC_STAGES < 1 || FILTER_LEN < 1 || CNT_W < 1) begin : g_bad_cfg
    $error("multi_edge_detect: NCH, SYNC_STAGES, FILTER_LEN and CNT_W must all be >= 1");
  end

  logic [NCH-1:0] level_w;
  logic [NCH-1:0] edge_w;
  logic [NCH-1:0] edge_nxt_w;
  logic [NCH-1:0] flag_w;
  logic           any_edge_q;

  for (genvar i = 0; i < NCH; i++) begin : g_chan
`ifdef EDGE_DETECT_CNT_EN
    logic [CNT_W-1:0] cnt_w;
`endif

    edge_chan #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILTER_LEN  (FILTER_LEN),
      .IDLE_BIT    (IDLE_VAL[i])
`ifdef EDGE_DETECT_CNT_EN
      , .CNT_W     (CNT_W)
`endif
    ) u_chan (
      .clk        (clk),
      .rst        (rst),
      .line       (bus.line_i[i]),
      .mode       (edge_mode_t'(bus.mode_i[MODE_W*i +: MODE_W])),
      .clr        (bus.clr_i[i]),
      .level      (level_w[i]),
      .edge_pulse (edge_w[i]),
      .edge_nxt   (edge_nxt_w[i]),
      .flag       (flag_w[i])
`ifdef EDGE_DETECT_CNT_EN
      , .cnt      (cnt_w)
`endif
    );

`ifdef EDGE_DETECT_CNT_EN
    assign bus.cnt_o[CNT_W*i +: CNT_W] = cnt_w;
`endif
  end

  // Registered from the channels' next-pulse values so it lines up with edge_o.
  always_ff @(posedge clk) begin
    if (rst) begin
      any_edge_q <= 1'b0;
    end else begin
      any_edge_q <= |edge_nxt_w;
    end
  end

  assign bus.level_o    = level_w;
  assign bus.edge_o     = edge_w;
  assign bus.any_edge_o = any_edge_q;
  assign bus.flag_o     = flag_w;

endmodule

// File: tb/tb_multi_edge_detect.sv
// tb/tb_multi_edge_detect.sv - scoreboard bench for multi_edge_detect (optional EDGE_DETECT_CNT_EN checks)

module tb_multi_edge_detect;
  import edge_detect_pkg::*;

  localparam int NCH   = 4;
  localparam int CNT_W = 2;
  localparam int LAT   = 5;

  typedef struct {
    int         cyc;
    logic [3:0] edge_v;
    logic [3:0] level;
    logic [3:0] flag;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  exp_t       q[$];
  exp_t       e;
  logic [3:0] line_m;
  logic [3:0] exp_flag;
  int         c0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  multi_edge_detect_if #(.NCH(NCH), .CNT_W(CNT_W)) bus ();

  multi_edge_detect #(
    .NCH         (NCH),
    .SYNC_STAGES (2),
    .FILTER_LEN  (3),
    .IDLE_VAL    (4'hF),
    .CNT_W       (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic set_line(input logic [3:0] v);
    bus.line_i = v;
    line_m     = v;
  endtask

  // Expected pulse LAT edges after the first sampling edge of the current line value.
  task automatic expect_edge(input logic [3:0] ev);
    exp_flag = exp_flag | ev;
    q.push_back('{cyc: cyc + LAT, edge_v: ev, level: line_m, flag: exp_flag});
  endtask

  // Monitor: every cycle that shows a pulse must match the next scoreboard entry.
  always @(negedge clk) begin
    if (bus.edge_o != 4'h0 || bus.any_edge_o) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse: got edge=%h any=%b at cyc %0d, required no pulse",
                 bus.edge_o, bus.any_edge_o, cyc);
      end else begin
        e = q.pop_front();
        if (cyc != e.cyc || bus.edge_o !== e.edge_v || bus.any_edge_o !== 1'b1 ||
            bus.level_o !== e.level || bus.flag_o !== e.flag) begin
          errors++;
          $display("FAIL pulse: got cyc=%0d edge=%h any=%b level=%h flag=%h required cyc=%0d edge=%h any=1 level=%h flag=%h",
                   cyc, bus.edge_o, bus.any_edge_o, bus.level_o, bus.flag_o,
                   e.cyc, e.edge_v, e.level, e.flag);
        end
      end
    end
  end

  initial begin
    rst         = 1'b1;
    bus.mode_i  = 8'h00;
    bus.clr_i   = 4'h0;
    exp_flag    = 4'h0;
    set_line(4'hF);
    tick(3);
    chk("reset_level", {4'h0, bus.level_o}, 8'h0F);
    chk("reset_edge",  {4'h0, bus.edge_o},  8'h00);
    chk("reset_flag",  {4'h0, bus.flag_o},  8'h00);
    rst = 1'b0;

    // 1) idle lines after reset: nothing moves
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk("idle_level", {4'h0, bus.level_o}, 8'h0F);
      chk("idle_flag",  {4'h0, bus.flag_o},  8'h00);
    end

    // 2) ch0 RISE: falling transition is masked, rising pulses
    bus.mode_i = 8'h01;
    set_line(4'hE);
    tick(10);
    chk("t2_level_low", {4'h0, bus.level_o}, 8'h0E);
    set_line(4'hF);
    expect_edge(4'h1);
    tick(8);
    chk("t2_flag", {4'h0, bus.flag_o}, 8'h01);
    tick(5);
    chk("t2_flag_sticky", {4'h0, bus.flag_o}, 8'h01);

    // 3) ch1 BOTH: 2-cycle glitch rejected, 3-cycle low accepted (then rises back)
    bus.mode_i = 8'h0D;
    set_line(4'hD);
    tick(2);
    set_line(4'hF);
    for (int i = 0; i < 8; i++) begin
      tick(1);
      chk("t3_glitch_level", {4'h0, bus.level_o}, 8'h0F);
    end
    set_line(4'hD);
    expect_edge(4'h2);
    tick(3);
    set_line(4'hF);
    expect_edge(4'h2);
    tick(10);

    // 4) ch2 FALL: clear coincident with the pulse loses, clear alone wins
    bus.mode_i = 8'h2D;
    set_line(4'hB);
    expect_edge(4'h4);
    tick(4);
    bus.clr_i = 4'h4;
    tick(1);
    chk("t4_set_wins", {4'h0, bus.flag_o}, 8'h07);
    tick(1);
    bus.clr_i = 4'h0;
    exp_flag  = exp_flag & ~4'h4;
    chk("t4_clear", {4'h0, bus.flag_o}, 8'h03);
    tick(8);

    // 5) all BOTH, all toggle together; reset mid-debounce discards changes
    bus.mode_i = 8'hFF;
    set_line(4'h4);
    expect_edge(4'hF);
    tick(10);
    chk("t5_level", {4'h0, bus.level_o}, 8'h04);
    set_line(4'hF);
    tick(2);
    rst = 1'b1;
    tick(1);
    rst      = 1'b0;
    exp_flag = 4'h0;
    tick(10);
    chk("t5_rst_level", {4'h0, bus.level_o}, 8'h0F);
    chk("t5_rst_flag",  {4'h0, bus.flag_o},  8'h00);
    // pending change at reset must requalify from the reset edge
    set_line(4'hE);
    c0 = cyc;
    tick(2);
    rst = 1'b1;
    tick(1);
    rst      = 1'b0;
    exp_flag = 4'h1;
    q.push_back('{cyc: c0 + 3 + LAT, edge_v: 4'h1, level: 4'hE, flag: 4'h1});
    tick(10);

    // 6) ch3 BOTH: five edges, then an edge coincident with clear
    for (int k = 0; k < 5; k++) begin
      set_line(line_m ^ 4'h8);
      expect_edge(4'h8);
      tick(8);
    end
`ifdef EDGE_DETECT_CNT_EN
    chk("t6_cnt3_sat", {6'h0, bus.cnt_o[3*CNT_W +: CNT_W]}, 8'h03);
    chk("t6_cnt0",     {6'h0, bus.cnt_o[0*CNT_W +: CNT_W]}, 8'h01);
`endif
    set_line(line_m ^ 4'h8);
    expect_edge(4'h8);
    tick(4);
    bus.clr_i = 4'h8;
    tick(1);
    bus.clr_i = 4'h0;
`ifdef EDGE_DETECT_CNT_EN
    chk("t6_cnt3_clr_edge", {6'h0, bus.cnt_o[3*CNT_W +: CNT_W]}, 8'h01);
`endif
    chk("t6_flag", {4'h0, bus.flag_o}, 8'h09);
    tick(5);

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL missing_pulses: got %0d expected pulses unseen, required 0", q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
